// File: rtl/req_enc_pkg.sv
// rtl/req_enc_pkg.sv - shared constants, state type and helpers for the request encoder
// Purpose: common definitions imported by the interface, selector and top.
// Ports: none (package).
package req_enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Converts a 3-bit index into the matching single-bit mask.
  function automatic logic [N_REQ-1:0] onehot3(input logic [CODE_W-1:0] code);
    onehot3 = N_REQ'(1) << code;
  endfunction

endpackage

// File: rtl/req_encoder8to3_if.sv
// rtl/req_encoder8to3_if.sv - request/offer handshake bundle for req_encoder8to3
// Purpose: groups request capture and offered-code handshake signals.
// Signals: E (capture enable), req[7:0] (request lines), A[2:0] (offered code),
//          valid (A holds a pending index), ready (consumer accepts), pending[7:0].
// Modports: master = request source / consumer side, slave = encoder side.
interface req_encoder8to3_if;
  import req_enc_pkg::*;

  logic              E;
  logic [N_REQ-1:0]  req;
  logic [CODE_W-1:0] A;
  logic              valid;
  logic              ready;
  logic [N_REQ-1:0]  pending;

  modport master (
    output E, req, ready,
    input  A, valid, pending
  );

  modport slave (
    input  E, req, ready,
    output A, valid, pending
  );

endinterface

// File: rtl/req_encoder8to3_pri_pick8.sv
// rtl/req_encoder8to3_pri_pick8.sv - combinational 8-way index selector
// Purpose: picks one set bit of vec, either highest index (fixed) or first set
//          bit searching downward from ptr-1 with wrap, ending at ptr (round-robin).
// Ports: vec[7:0] candidates, ptr[2:0] last grant, rr_en mode select,
//        code[2:0] selected index, any = at least one bit set.
module pri_pick8
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  input  logic [CODE_W-1:0] ptr,
  input  logic              rr_en,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  logic [CODE_W-1:0] idx;

  always_comb begin
    code = '0;
    idx  = '0;
    any  = |vec;
    if (rr_en) begin
      // Walk from the farthest candidate (ptr itself) to the nearest (ptr-1)
      // so the last hit, i.e. the nearest one below ptr, wins.
      for (int i = N_REQ; i >= 1; i--) begin
        idx = ptr - CODE_W'(i);
        if (vec[idx]) code = idx;
      end
    end else begin
      // Ascending scan: the highest set index is written last.
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/req_encoder8to3.sv
// rtl/req_encoder8to3.sv - registered 8-to-3 request encoder with valid/ready offer
// Purpose: collects sticky request bits and offers one pending index at a time,
//          clearing it when the consumer accepts.
// Parameters: RR_EN (0 fixed priority, 1 round-robin), PEND_OUT_EN (expose pending).
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport: E, req, ready
//        in; A, valid, pending out). All outputs come straight from flops.
module req_encoder8to3
  import req_enc_pkg::*;
#(
  parameter bit RR_EN       = 1'b0,
  parameter bit PEND_OUT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  req_encoder8to3_if.slave   bus
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] a_q, a_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;

  logic              accept;
  logic [N_REQ-1:0]  clr;
  logic [CODE_W-1:0] pick_ptr;
  logic [CODE_W-1:0] pick_code;
  logic              pick_any;

  assign accept = (state_q == OFFER) && bus.ready;
  assign clr    = accept ? onehot3(a_q) : '0;

  // New requests are OR-ed in after the clear, so re-requesting the bit
  // being accepted keeps it pending.
  assign pend_d = (pend_q & ~clr) | (bus.E ? bus.req : '0);

  // On an accept in round-robin mode the new rr_ptr equals a_q, so the
  // reload path can search from a_q directly.
  assign pick_ptr = (state_q == OFFER) ? a_q : rr_ptr_q;

  pri_pick8 u_pick (
    .vec   (pend_d),
    .ptr   (pick_ptr),
    .rr_en (RR_EN),
    .code  (pick_code),
    .any   (pick_any)
  );

  assign rr_ptr_d = (RR_EN && accept) ? a_q : rr_ptr_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OFFER;
          a_d     = pick_code;
        end
      end
      OFFER: begin
        // A stays frozen until accepted, even if a higher request shows up.
        if (bus.ready) begin
          if (pick_any) begin
            a_d = pick_code;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      pend_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.valid   = (state_q == OFFER);
  assign bus.pending = PEND_OUT_EN ? pend_q : '0;

endmodule

// File: tb/tb_req_encoder8to3.sv
// tb/tb_req_encoder8to3.sv - directed scoreboard bench for req_encoder8to3
module tb_req_encoder8to3;

  typedef struct packed {
    logic       valid;
    logic [2:0] a;
    logic [7:0] pend;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  req_encoder8to3_if if_f ();
  req_encoder8to3_if if_r ();

  req_encoder8to3 #(.RR_EN(1'b0), .PEND_OUT_EN(1'b1)) u_fix (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_f.slave)
  );

  req_encoder8to3 #(.RR_EN(1'b1), .PEND_OUT_EN(1'b1)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_r.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: queue the expected registered outputs, drive both DUTs with the
  // same stimulus, then pop and compare against the DUT selected by m.
  task automatic cyc(input string tag, input bit m, input bit rst, input bit e,
                     input logic [7:0] r, input bit rdy,
                     input bit ev, input logic [2:0] ea, input logic [7:0] ep);
    exp_t x;
    exp_q.push_back('{valid: ev, a: ea, pend: ep});
    rst_n     = rst;
    if_f.E    = e;  if_f.req = r;  if_f.ready = rdy;
    if_r.E    = e;  if_r.req = r;  if_r.ready = rdy;
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    if (m) begin
      chk({tag, ".valid"}, 8'(if_r.valid), 8'(x.valid));
      chk({tag, ".A"},     8'(if_r.A),     8'(x.a));
      chk({tag, ".pend"},  if_r.pending,   x.pend);
    end else begin
      chk({tag, ".valid"}, 8'(if_f.valid), 8'(x.valid));
      chk({tag, ".A"},     8'(if_f.A),     8'(x.a));
      chk({tag, ".pend"},  if_f.pending,   x.pend);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if_f.E = 1'b0; if_f.req = '0; if_f.ready = 1'b0;
    if_r.E = 1'b0; if_r.req = '0; if_r.ready = 1'b0;

    // 1: reset and idle, ready while idle is ignored, requests in reset dropped
    cyc("rst",    0, 0, 1, 8'h00, 0, 0, 3'd0, 8'h00);
    for (int i = 0; i < 5; i++)
      cyc("idle", 0, 1, 1, 8'h00, i[0], 0, 3'd0, 8'h00);
    cyc("rst_ff", 0, 0, 1, 8'hFF, 0, 0, 3'd0, 8'h00);
    cyc("post",   0, 1, 1, 8'h00, 0, 0, 3'd0, 8'h00);

    // 2: fixed priority drain of A4 with ready held
    cyc("fx_a4_0", 0, 1, 1, 8'hA4, 1, 1, 3'd7, 8'hA4);
    cyc("fx_a4_1", 0, 1, 1, 8'h00, 1, 1, 3'd5, 8'h24);
    cyc("fx_a4_2", 0, 1, 1, 8'h00, 1, 1, 3'd2, 8'h04);
    cyc("fx_a4_3", 0, 1, 1, 8'h00, 1, 0, 3'd2, 8'h00);

    // 3: offer frozen while ready=0 despite higher request
    cyc("hold_0", 0, 1, 1, 8'h01, 0, 1, 3'd0, 8'h01);
    cyc("hold_1", 0, 1, 1, 8'h80, 0, 1, 3'd0, 8'h81);
    cyc("hold_2", 0, 1, 1, 8'h00, 0, 1, 3'd0, 8'h81);
    cyc("hold_3", 0, 1, 1, 8'h00, 1, 1, 3'd7, 8'h80);
    cyc("hold_4", 0, 1, 1, 8'h00, 1, 0, 3'd7, 8'h00);

    // 4: re-request of the accepted bit stays pending
    cyc("rereq_0", 0, 1, 1, 8'h08, 0, 1, 3'd3, 8'h08);
    cyc("rereq_1", 0, 1, 1, 8'h08, 1, 1, 3'd3, 8'h08);
    cyc("rereq_2", 0, 1, 1, 8'h00, 1, 0, 3'd3, 8'h00);

    // 6: capture enable low ignores req but still drains
    cyc("e0_0", 0, 1, 0, 8'hFF, 0, 0, 3'd3, 8'h00);
    cyc("e0_1", 0, 1, 1, 8'h10, 0, 1, 3'd4, 8'h10);
    cyc("e0_2", 0, 1, 0, 8'hFF, 0, 1, 3'd4, 8'h10);
    cyc("e0_3", 0, 1, 0, 8'hFF, 1, 0, 3'd4, 8'h00);

    // reset mid-offer, then round-robin
    cyc("pre_rr", 0, 1, 1, 8'h20, 0, 1, 3'd5, 8'h20);
    cyc("rst_mid", 0, 0, 1, 8'h00, 0, 0, 3'd0, 8'h00);
    cyc("rr_rst",  1, 0, 1, 8'h00, 0, 0, 3'd0, 8'h00);

    // 5: round-robin full drain 7..0
    cyc("rr_ff_7", 1, 1, 1, 8'hFF, 1, 1, 3'd7, 8'hFF);
    cyc("rr_ff_6", 1, 1, 1, 8'h00, 1, 1, 3'd6, 8'h7F);
    cyc("rr_ff_5", 1, 1, 1, 8'h00, 1, 1, 3'd5, 8'h3F);
    cyc("rr_ff_4", 1, 1, 1, 8'h00, 1, 1, 3'd4, 8'h1F);
    cyc("rr_ff_3", 1, 1, 1, 8'h00, 1, 1, 3'd3, 8'h0F);
    cyc("rr_ff_2", 1, 1, 1, 8'h00, 1, 1, 3'd2, 8'h07);
    cyc("rr_ff_1", 1, 1, 1, 8'h00, 1, 1, 3'd1, 8'h03);
    cyc("rr_ff_0", 1, 1, 1, 8'h00, 1, 1, 3'd0, 8'h01);
    cyc("rr_ff_e", 1, 1, 1, 8'h00, 1, 0, 3'd0, 8'h00);
    // wrap after grant 0
    cyc("rr_81_7", 1, 1, 1, 8'h81, 1, 1, 3'd7, 8'h81);
    cyc("rr_81_0", 1, 1, 1, 8'h00, 1, 1, 3'd0, 8'h01);
    cyc("rr_81_e", 1, 1, 1, 8'h00, 1, 0, 3'd0, 8'h00);
    cyc("rr_03_1", 1, 1, 1, 8'h03, 1, 1, 3'd1, 8'h03);
    cyc("rr_03_0", 1, 1, 1, 8'h00, 1, 1, 3'd0, 8'h01);
    cyc("rr_03_e", 1, 1, 1, 8'h00, 1, 0, 3'd0, 8'h00);
    // after grant 5, bit 3 is served before the newly arrived bit 7
    cyc("rr_w_5", 1, 1, 1, 8'h28, 0, 1, 3'd5, 8'h28);
    cyc("rr_w_3", 1, 1, 1, 8'h80, 1, 1, 3'd3, 8'h88);
    cyc("rr_w_7", 1, 1, 1, 8'h00, 1, 1, 3'd7, 8'h80);
    cyc("rr_w_e", 1, 1, 1, 8'h00, 1, 0, 3'd7, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
